// File: rtl/ct_mmu_sysmap_lookup.sv
// Sysmap lookup front end: round-robin arbitration of PTW/CP0 page lookups, registered PA to the
// comparator, captured flag/hit response. Grant at T, resp_vld at T+2; the response is held while resp_rdy is low.
module ct_mmu_sysmap_lookup #(
    parameter int                   ADDR_WIDTH = 28,
    parameter int                   FLG_WIDTH  = 5,
    parameter int                   HIT_WIDTH  = 8,
    parameter logic [FLG_WIDTH-1:0] DEF_FLG    = 5'b10011
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  ptw_sysmap_req,
    input  logic [ADDR_WIDTH-1:0] ptw_sysmap_pa,
    input  logic                  ptw_sysmap_flush,
    output logic                  sysmap_ptw_gnt,
    input  logic                  cp0_sysmap_req,
    input  logic [ADDR_WIDTH-1:0] cp0_sysmap_pa,
    output logic                  sysmap_cp0_gnt,
    output logic [ADDR_WIDTH-1:0] mmu_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]  sysmap_mmu_flg_y,
    input  logic [HIT_WIDTH-1:0]  sysmap_mmu_hit_y,
    output logic                  sysmap_resp_vld,
    input  logic                  sysmap_resp_rdy,
    output logic                  sysmap_resp_src,
    output logic [FLG_WIDTH-1:0]  sysmap_resp_flg,
    output logic [HIT_WIDTH-1:0]  sysmap_resp_hit,
    output logic                  sysmap_resp_miss,
    output logic                  sysmap_resp_multi
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOOK = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  src_q, src_d;
    logic [ADDR_WIDTH-1:0] pa_q, pa_d;
    logic [FLG_WIDTH-1:0]  flg_q, flg_d;
    logic [HIT_WIDTH-1:0]  hit_q, hit_d;
    logic                  miss_q, miss_d;
    logic                  multi_q, multi_d;

    logic ptw_gnt, cp0_gnt, ptw_eligible, src_flush, hit_none, hit_multi;

    // Flush only removes a PTW request from arbitration; CP0 can still win that cycle.
    always_comb begin
        ptw_eligible = ptw_sysmap_req & ~ptw_sysmap_flush;
        ptw_gnt      = 1'b0;
        cp0_gnt      = 1'b0;
        if (state_q == ST_IDLE && !cpurst) begin
            if (!rr_q) begin
                ptw_gnt = ptw_eligible;
                cp0_gnt = ~ptw_eligible & cp0_sysmap_req;
            end else begin
                cp0_gnt = cp0_sysmap_req;
                ptw_gnt = ~cp0_sysmap_req & ptw_eligible;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more regions hit.
    assign hit_none  = ~|sysmap_mmu_hit_y;
    assign hit_multi = |(sysmap_mmu_hit_y & (sysmap_mmu_hit_y - {{(HIT_WIDTH-1){1'b0}}, 1'b1}));
    assign src_flush = ~src_q & ptw_sysmap_flush;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        pa_d    = pa_q;
        flg_d   = flg_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        multi_d = multi_q;
        case (state_q)
            ST_IDLE: begin
                if (ptw_gnt) begin
                    pa_d    = ptw_sysmap_pa;
                    src_d   = 1'b0;
                    rr_d    = 1'b1;
                    state_d = ST_LOOK;
                end else if (cp0_gnt) begin
                    pa_d    = cp0_sysmap_pa;
                    src_d   = 1'b1;
                    rr_d    = 1'b0;
                    state_d = ST_LOOK;
                end
            end
            ST_LOOK: begin
                if (src_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hit_d   = sysmap_mmu_hit_y;
                    miss_d  = hit_none;
                    multi_d = hit_multi;
                    flg_d   = (hit_none || hit_multi) ? DEF_FLG : sysmap_mmu_flg_y;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (src_flush || sysmap_resp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            src_q   <= 1'b0;
            pa_q    <= '0;
            flg_q   <= '0;
            hit_q   <= '0;
            miss_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            pa_q    <= pa_d;
            flg_q   <= flg_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            multi_q <= multi_d;
        end
    end

    assign sysmap_ptw_gnt    = ptw_gnt;
    assign sysmap_cp0_gnt    = cp0_gnt;
    assign mmu_sysmap_pa_y   = pa_q;
    assign sysmap_resp_vld   = (state_q == ST_RESP);
    assign sysmap_resp_src   = src_q;
    assign sysmap_resp_flg   = flg_q;
    assign sysmap_resp_hit   = hit_q;
    assign sysmap_resp_miss  = miss_q;
    assign sysmap_resp_multi = multi_q;

endmodule

// File: doc/ct_mmu_sysmap_lookup.md
Name: ct_mmu_sysmap_lookup

Overview:
- Request-side front end for the sysmap attribute comparator.
- Arbitrates lookup requests from the page-table walker (PTW) and the CP0 debug probe.
- Drives the registered physical page number onto mmu_sysmap_pa_y, captures the returned 5-bit flag and 8-bit region-hit vector, and returns a tagged, held response with valid/ready handshake.
- Sits between PTW/CP0 and the combinational sysmap comparator.

Parameters:
ADDR_WIDTH, 28, physical page number width (PA_WIDTH-12)
FLG_WIDTH, 5, sysmap attribute flag width
HIT_WIDTH, 8, number of sysmap regions
DEF_FLG, 5'b10011, flag reported when no region, or more than one region, hits

Ports:
forever_cpuclk  in  1  block clock
cpurst  in  1  synchronous, active-high reset
ptw_sysmap_req  in  1  PTW lookup request; held until granted
ptw_sysmap_pa  in  ADDR_WIDTH  PTW physical page number
ptw_sysmap_flush  in  1  abandon any in-flight PTW lookup
sysmap_ptw_gnt  out  1  PTW request accepted this cycle
cp0_sysmap_req  in  1  CP0 probe request; held until granted
cp0_sysmap_pa  in  ADDR_WIDTH  CP0 physical page number
sysmap_cp0_gnt  out  1  CP0 request accepted this cycle
mmu_sysmap_pa_y  out  ADDR_WIDTH  registered PA to comparator
sysmap_mmu_flg_y  in  FLG_WIDTH  comparator flag (combinational from pa_y)
sysmap_mmu_hit_y  in  HIT_WIDTH  comparator region hit vector
sysmap_resp_vld  out  1  response valid
sysmap_resp_rdy  in  1  consumer accepts response
sysmap_resp_src  out  1  response owner: 0 = PTW, 1 = CP0
sysmap_resp_flg  out  FLG_WIDTH  captured flag
sysmap_resp_hit  out  HIT_WIDTH  captured hit vector
sysmap_resp_miss  out  1  no region hit
sysmap_resp_multi  out  1  more than one region hit

Behaviour:
- Sole interface decision: one clock, forever_cpuclk. Reset cpurst is synchronous and active-high.
- Reset values:
  - FSM = IDLE; rr pointer = 0 (PTW preferred).
  - mmu_sysmap_pa_y = 0.
  - All resp_* = 0; both grants = 0.
- FSM states:
  - IDLE: grant only here.
    - Grant goes to the pointer's side if it is requesting, otherwise to the other side.
    - The gnt signal is a 1-cycle combinational pulse.
    - On grant: latch PA into mmu_sysmap_pa_y, latch src, toggle the pointer to the non-granted side, go to LOOK.
    - With no request, stay in IDLE.
  - LOOK: the comparator output is valid this cycle.
    - Capture flg/hit into the resp registers.
    - miss = (hit == 0); multi = (popcount(hit) > 1).
    - If miss or multi, resp_flg = DEF_FLG regardless of the input flag.
    - Go to RESP.
  - RESP: resp_vld = 1 with all resp fields held stable.
    - On resp_rdy, go to IDLE and drop resp_vld the next cycle.
    - No back-to-back grant in the same cycle as the handshake.
- Latency: grant at cycle T, resp_vld at T+2, minimum issue interval 3 cycles. resp_vld can remain high indefinitely while rdy = 0.
- Flush: ptw_sysmap_flush applies only when src = 0.
  - In LOOK: go to IDLE with no response.
  - In RESP: drop resp_vld next cycle and go to IDLE.
  - In IDLE: suppress the PTW grant that cycle; a CP0 request may still be granted.
  - When src = 1 (CP0), flush is ignored.
- Simultaneous events:
  - Both requesting in IDLE: the pointer decides.
  - flush and resp_rdy together in RESP: treated as flush, same next state.
- Reset mid-operation: return to IDLE immediately, with no response generated.
- mmu_sysmap_pa_y changes only on a grant.

Test Plan:
- PTW request PA = 28'h0000400, comparator returns hit = 8'h02, flg = 5'b01101 -> gnt at T, resp_vld at T+2, src = 0, flg = 5'b01101, hit = 8'h02, miss = 0, multi = 0.
- PTW and CP0 request together for 4 transactions with rdy = 1 -> grants alternate PTW, CP0, PTW, CP0; each resp_src matches its grant.
- hit = 8'h00 and, separately, hit = 8'h0C -> resp_flg = 5'b10011, with miss = 1 and multi = 1 respectively.
- resp_rdy held low for 10 cycles -> resp_vld and all fields stable, no further gnt; rdy = 1 -> IDLE, next grant 1 cycle later.
- ptw_sysmap_flush in LOOK for a PTW lookup -> no resp_vld. Flush during a CP0 lookup -> response is delivered normally.
- cpurst asserted in RESP -> next cycle resp_vld = 0, pa_y = 0, FSM in IDLE, pointer = 0.
